dcache_mem_ctrl: RTL and testbench

- Sits between the L1 data cache and the L2/memory data port (`mem_*0` read and write channels).
- Buffers write-through stores in a FIFO and drains them one at a time using the memory write-done handshake.
- Runs one outstanding line-fill miss at a time: issues the line read, waits for data-ready, and returns the line to the L1 as a one-cycle fill.
- Enforces read-after-write ordering between buffered stores and the pending line read.

---
 rtl/dcache_ctrl_pkg.sv | 37 +++
 rtl/dcache_wb_fifo.sv | 60 ++++++
 rtl/dcache_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types, geometry constants and address helpers for the L1 data-cache
// memory-side controller.
package dcache_ctrl_pkg;

  // Cache geometry: 32-bit words, 16-byte lines, 64 sets.
  localparam int SIZE_DATA          = 32;
  localparam int DCACHE_LINE_SIZE   = 128;
  localparam int DCACHE_OFFSET_BITS = 2;
  localparam int DCACHE_INDEX_BITS  = 6;
  localparam int LINE_LSB           = DCACHE_OFFSET_BITS + 2;
  localparam int DCACHE_TAG_BITS    = 32 - DCACHE_INDEX_BITS - LINE_LSB;
  localparam int LINE_ADDR_BITS     = 32 - LINE_LSB;

  typedef struct packed {
    logic [31:0]          addr;
    logic [SIZE_DATA-1:0] data;
    logic [3:0]           be;
  } wb_entry_t;

  typedef enum logic [1:0] {WB_IDLE, WB_ISSUE, WB_WAIT} wb_state_t;

  typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_REQ, R_WAIT, R_FILL} miss_state_t;

  // Line number of a byte address (word and byte offset removed).
  function automatic logic [LINE_ADDR_BITS-1:0] line_addr(input logic [31:0] addr);
    return LINE_ADDR_BITS'(addr >> LINE_LSB);
  endfunction

  function automatic logic [DCACHE_TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
    return DCACHE_TAG_BITS'(addr >> (32 - DCACHE_TAG_BITS));
  endfunction

  function automatic logic [DCACHE_INDEX_BITS-1:0] addr_index(input logic [31:0] addr);
    return DCACHE_INDEX_BITS'(addr >> LINE_LSB);
  endfunction

endpackage

// File: rtl/dcache_wb_fifo.sv
// Write-through store buffer: circular FIFO with a line-match probe so the
// miss path can wait for older stores to the same line.
module dcache_wb_fifo
  import dcache_ctrl_pkg::*;
#(
  parameter int WB_DEPTH    = 4,
  parameter int WB_PTR_BITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic [WB_PTR_BITS:0]      count,
  input  logic [LINE_ADDR_BITS-1:0] query_line,
  output logic [WB_DEPTH-1:0]       match
);

  wb_entry_t              entries [WB_DEPTH];
  logic [WB_PTR_BITS-1:0] wr_ptr;
  logic [WB_PTR_BITS-1:0] rd_ptr;

  // Entry storage written at the tail.
  // NOTE: storage has no reset; the pointers and count define which entries are valid, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + WB_PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + WB_PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + (WB_PTR_BITS+1)'(1);
        2'b01:   count <= count - (WB_PTR_BITS+1)'(1);
        default: ;
      endcase
    end
  end

  assign head = entries[rd_ptr];

  // Flag every valid entry whose line equals the query line.
  // NOTE: the default assignment comes first so no path leaves match unassigned (no latch).
  always_comb begin
    match = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      match[i] = ({1'b0, WB_PTR_BITS'(WB_PTR_BITS'(i) - rd_ptr)} < count) &&
                 (line_addr(entries[i].addr) == query_line);
    end
  end

endmodule

// File: rtl/dcache_mem_ctrl.sv
// L1 data-cache memory-side controller: drains buffered write-through stores
// and runs one line-fill miss at a time, keeping reads behind older stores
// to the same line.
module dcache_mem_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int WB_DEPTH    = 4,
  parameter int WB_PTR_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid_i,
  output logic                         st_ready_o,
  input  logic [31:0]                  st_addr_i,
  input  logic [SIZE_DATA-1:0]         st_data_i,
  input  logic [3:0]                   st_byte_en_i,
  input  logic                         miss_valid_i,
  output logic                         miss_ready_o,
  input  logic [31:0]                  miss_addr_i,
  output logic                         fill_valid_o,
  output logic [DCACHE_LINE_SIZE-1:0]  fill_data_o,
  output logic [DCACHE_TAG_BITS-1:0]   fill_tag_o,
  output logic [DCACHE_INDEX_BITS-1:0] fill_index_o,
  output logic                         wb_empty_o,
  output logic [31:0]                  mem_addr0_o,
  output logic                         mem_re0_o,
  input  logic [DCACHE_LINE_SIZE-1:0]  mem_data0_i,
  input  logic                         mem_data_ready0_i,
  input  logic [DCACHE_TAG_BITS-1:0]   mem_tag0_i,
  input  logic [DCACHE_INDEX_BITS-1:0] mem_index0_i,
  output logic [31:0]                  mem_wr_addr0_o,
  output logic                         mem_we0_o,
  output logic [SIZE_DATA-1:0]         mem_wr_data0_o,
  output logic [3:0]                   mem_wr_byte_en0_o,
  input  logic                         mem_wr_done0_i
);

  localparam logic [31:0] LINE_MASK = 32'((1 << LINE_LSB) - 1);

  wb_state_t              wb_state, wb_next;
  miss_state_t            miss_state, miss_next;
  wb_entry_t              head;
  logic [WB_PTR_BITS:0]   wb_count;
  logic [WB_DEPTH-1:0]    wb_match;
  logic [31:0]            miss_addr_q;
  logic                   push, pop, miss_accept, read_blocked, in_flight_match;

  assign st_ready_o      = (wb_count != (WB_PTR_BITS+1)'(WB_DEPTH));
  assign push            = st_valid_i && st_ready_o;
  assign pop             = (wb_state == WB_WAIT) && mem_wr_done0_i;
  assign wb_empty_o      = (wb_count == '0) && (wb_state == WB_IDLE);
  assign miss_ready_o    = (miss_state == R_IDLE);
  assign miss_accept     = miss_valid_i && miss_ready_o;
  assign read_blocked    = (miss_state == R_REQ) || (miss_state == R_WAIT);
  assign in_flight_match = (wb_state != WB_IDLE) &&
                           (line_addr(mem_wr_addr0_o) == line_addr(miss_addr_q));

  dcache_wb_fifo #(.WB_DEPTH(WB_DEPTH), .WB_PTR_BITS(WB_PTR_BITS)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{addr: st_addr_i, data: st_data_i, be: st_byte_en_i}),
    .pop        (pop),
    .head       (head),
    .count      (wb_count),
    .query_line (line_addr(miss_addr_q)),
    .match      (wb_match)
  );

  // State registers for both FSMs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_state   <= WB_IDLE;
      miss_state <= R_IDLE;
    end else begin
      wb_state   <= wb_next;
      miss_state <= miss_next;
    end
  end

  // Drain FSM next state: issue the head store unless a line read is on the bus.
  always_comb begin
    wb_next = wb_state;
    case (wb_state)
      WB_IDLE:  if ((wb_count != '0) && !read_blocked) wb_next = WB_ISSUE;
      WB_ISSUE: wb_next = WB_WAIT;
      WB_WAIT:  if (mem_wr_done0_i) wb_next = WB_IDLE;
      default:  wb_next = WB_IDLE;
    endcase
  end

  // Write port: strobe is high exactly while in WB_ISSUE; address/data hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we0_o         <= 1'b0;
      mem_wr_addr0_o    <= '0;
      mem_wr_data0_o    <= '0;
      mem_wr_byte_en0_o <= '0;
    end else begin
      mem_we0_o <= (wb_next == WB_ISSUE);
      if (wb_state == WB_IDLE && wb_next == WB_ISSUE) begin
        mem_wr_addr0_o    <= head.addr;
        mem_wr_data0_o    <= head.data;
        mem_wr_byte_en0_o <= head.be;
      end
    end
  end

  // Miss FSM next state: wait out same-line stores, then request, wait, fill.
  always_comb begin
    miss_next = miss_state;
    case (miss_state)
      R_IDLE:  if (miss_valid_i) miss_next = R_DRAIN;
      R_DRAIN: if (!(|wb_match) && !in_flight_match) miss_next = R_REQ;
      R_REQ:   miss_next = R_WAIT;
      R_WAIT:  if (mem_data_ready0_i) miss_next = R_FILL;
      R_FILL:  miss_next = R_IDLE;
      default: miss_next = R_IDLE;
    endcase
  end

  // Read port and fill outputs; fill data/tag/index hold until the next fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_addr_q  <= '0;
      mem_re0_o    <= 1'b0;
      mem_addr0_o  <= '0;
      fill_valid_o <= 1'b0;
      fill_data_o  <= '0;
      fill_tag_o   <= '0;
      fill_index_o <= '0;
    end else begin
      if (miss_accept) miss_addr_q <= miss_addr_i;
      mem_re0_o    <= (miss_next == R_REQ);
      fill_valid_o <= (miss_next == R_FILL);
      if (miss_state == R_DRAIN && miss_next == R_REQ) mem_addr0_o <= miss_addr_q & ~LINE_MASK;
      if (miss_state == R_WAIT && mem_data_ready0_i) begin
        fill_data_o  <= mem_data0_i;
        fill_tag_o   <= addr_tag(miss_addr_q);
        fill_index_o <= addr_index(miss_addr_q);
      end
    end
  end

  // Returned tag/index must belong to the outstanding miss.
  a_fill_tag_match: assert property (@(posedge clk) disable iff (reset)
    (miss_state == R_WAIT && mem_data_ready0_i) |->
      (mem_tag0_i == addr_tag(miss_addr_q) && mem_index0_i == addr_index(miss_addr_q)));

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with a small memory responder.
module tb_dcache_mem_ctrl;
  import dcache_ctrl_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         st_valid_i = 1'b0;
  logic                         st_ready_o;
  logic [31:0]                  st_addr_i = '0;
  logic [SIZE_DATA-1:0]         st_data_i = '0;
  logic [3:0]                   st_byte_en_i = '0;
  logic                         miss_valid_i = 1'b0;
  logic                         miss_ready_o;
  logic [31:0]                  miss_addr_i = '0;
  logic                         fill_valid_o;
  logic [DCACHE_LINE_SIZE-1:0]  fill_data_o;
  logic [DCACHE_TAG_BITS-1:0]   fill_tag_o;
  logic [DCACHE_INDEX_BITS-1:0] fill_index_o;
  logic                         wb_empty_o;
  logic [31:0]                  mem_addr0_o;
  logic                         mem_re0_o;
  logic [DCACHE_LINE_SIZE-1:0]  mem_data0_i;
  logic                         mem_data_ready0_i;
  logic [DCACHE_TAG_BITS-1:0]   mem_tag0_i;
  logic [DCACHE_INDEX_BITS-1:0] mem_index0_i;
  logic [31:0]                  mem_wr_addr0_o;
  logic                         mem_we0_o;
  logic [SIZE_DATA-1:0]         mem_wr_data0_o;
  logic [3:0]                   mem_wr_byte_en0_o;
  logic                         mem_wr_done0_i;

  dcache_mem_ctrl #(.WB_DEPTH(4), .WB_PTR_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_byte_en_i(st_byte_en_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o), .fill_tag_o(fill_tag_o),
    .fill_index_o(fill_index_o), .wb_empty_o(wb_empty_o),
    .mem_addr0_o(mem_addr0_o), .mem_re0_o(mem_re0_o), .mem_data0_i(mem_data0_i),
    .mem_data_ready0_i(mem_data_ready0_i), .mem_tag0_i(mem_tag0_i), .mem_index0_i(mem_index0_i),
    .mem_wr_addr0_o(mem_wr_addr0_o), .mem_we0_o(mem_we0_o), .mem_wr_data0_o(mem_wr_data0_o),
    .mem_wr_byte_en0_o(mem_wr_byte_en0_o), .mem_wr_done0_i(mem_wr_done0_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic auto_wr = 1'b1, auto_rd = 1'b1, manual_done = 1'b0, manual_ready = 1'b0;
  logic wr_pending = 1'b0, rd_pending = 1'b0, done_q = 1'b0, rdy_q = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [DCACHE_LINE_SIZE-1:0]  rd_data_q = '0;
  logic [DCACHE_TAG_BITS-1:0]   rd_tag_q = '0;
  logic [DCACHE_INDEX_BITS-1:0] rd_index_q = '0;
  logic [31:0] tb_mem [logic [31:0]];
  wb_entry_t wlog[$];
  int we_pulses = 0, fill_pulses = 0;

  assign mem_wr_done0_i    = done_q || manual_done;
  assign mem_data_ready0_i = rdy_q || manual_ready;
  assign mem_data0_i       = rd_data_q;
  assign mem_tag0_i        = rd_tag_q;
  assign mem_index0_i      = rd_index_q;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 32'hdeadbeef;
  endfunction

  // Responds one cycle after each strobe; writes land in tb_mem.
  always @(negedge clk) begin
    logic [31:0] w, wa;
    if (reset) begin
      wr_pending = 1'b0; rd_pending = 1'b0; done_q = 1'b0; rdy_q = 1'b0;
    end else begin
      done_q = auto_wr && wr_pending;
      if (done_q) wr_pending = 1'b0;
      if (mem_we0_o) begin
        wr_pending = 1'b1;
        we_pulses++;
        wlog.push_back('{addr: mem_wr_addr0_o, data: mem_wr_data0_o, be: mem_wr_byte_en0_o});
        wa = mem_wr_addr0_o & ~32'h3;
        w  = rd_word(wa);
        for (int b = 0; b < 4; b++) if (mem_wr_byte_en0_o[b]) w[8*b +: 8] = mem_wr_data0_o[8*b +: 8];
        tb_mem[wa] = w;
      end
      rdy_q = auto_rd && rd_pending;
      if (rdy_q) begin
        rd_pending = 1'b0;
        for (int k = 0; k < 4; k++) rd_data_q[32*k +: 32] = rd_word(rd_addr + 32'(4*k));
        rd_tag_q   = addr_tag(rd_addr);
        rd_index_q = addr_index(rd_addr);
      end
      if (mem_re0_o) begin
        rd_pending = 1'b1;
        rd_addr    = mem_addr0_o;
      end
      if (fill_valid_o) fill_pulses++;
    end
  end

  // Sampling and driving happen 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_byte_en_i = be;
  endtask

  localparam logic [127:0] ALL_DEAD = {4{32'hdeadbeef}};

  initial begin
    int base, re_c, done_c, fill_c, we_c, pulses, snap_we, snap_fill;
    bit seen;
    logic [127:0] cap_data;
    logic [31:0]  cap_tag, cap_idx, cap_addr;

    // ---- reset state ----
    #1;
    check("rst_st_ready", st_ready_o, 1);
    check("rst_miss_ready", miss_ready_o, 1);
    check("rst_wb_empty", wb_empty_o, 1);
    check("rst_outs", {mem_we0_o, mem_re0_o, fill_valid_o}, 0);
    check("rst_addrs", {mem_addr0_o, mem_wr_addr0_o, mem_wr_data0_o}, 0);
    check("rst_fill_data", fill_data_o, 0);
    step(); step();
    reset = 1'b0;
    step();

    // ---- single store ----
    snap_we = we_pulses;
    drive_store(32'h100, 32'hAABBCCDD, 4'b0011);
    step(); st_valid_i = 1'b0;
    check("s1_empty_after_push", wb_empty_o, 0);
    step();
    check("s1_we", mem_we0_o, 1);
    check("s1_wr_addr", mem_wr_addr0_o, 32'h100);
    check("s1_wr_data", mem_wr_data0_o, 32'hAABBCCDD);
    check("s1_wr_be", mem_wr_byte_en0_o, 4'b0011);
    step();
    check("s1_we_one_cycle", mem_we0_o, 0);
    check("s1_empty_2cyc", wb_empty_o, 0);
    step();
    check("s1_empty_3cyc", wb_empty_o, 1);
    step(); step();
    check("s1_we_pulses", we_pulses - snap_we, 1);

    // ---- five stores into a four-deep buffer ----
    auto_wr = 1'b0;
    base = wlog.size();
    for (int k = 0; k < 4; k++) begin
      step();
      check("s2_ready_before_push", st_ready_o, 1);
      drive_store(32'h1000 + 32'(4*k), 32'hC0DE0000 + 32'(k), 4'hF);
    end
    step();
    check("s2_full_ready_low", st_ready_o, 0);
    drive_store(32'h1010, 32'hC0DE0004, 4'hF);
    for (int k = 0; k < 3; k++) begin
      step();
      check("s2_held_ready_low", st_ready_o, 0);
    end
    check("s2_one_issued", wlog.size() - base, 1);
    auto_wr = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (st_ready_o) seen = 1'b1;
    end
    check("s2_ready_after_pop", seen, 1);
    step(); st_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (wb_empty_o) seen = 1'b1;
    end
    check("s2_drained", seen, 1);
    check("s2_write_count", wlog.size() - base, 5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < wlog.size()) begin
        check("s2_order_addr", wlog[base+k].addr, 32'h1000 + 32'(4*k));
        check("s2_order_data", wlog[base+k].data, 32'hC0DE0000 + 32'(k));
      end
    end

    // ---- read-after-write to the same line ----
    step();
    drive_store(32'h204, 32'h11223344, 4'hF);
    step(); st_valid_i = 1'b0;
    miss_valid_i = 1'b1; miss_addr_i = 32'h208;
    step(); miss_valid_i = 1'b0;
    re_c = -1; done_c = -1; fill_c = -1; cap_addr = '0;
    for (int c = 0; c < 40 && fill_c < 0; c++) begin
      step();
      if (mem_wr_done0_i && done_c < 0) done_c = c;
      if (mem_re0_o && re_c < 0) begin re_c = c; cap_addr = mem_addr0_o; end
      if (fill_valid_o) fill_c = c;
    end
    check("s3_done_seen", done_c >= 0, 1);
    check("s3_re_after_done", re_c > done_c, 1);
    check("s3_mem_addr", cap_addr, 32'h200);
    check("s3_fill_seen", fill_c >= 0, 1);
    check("s3_fill_data", fill_data_o, 128'hdeadbeef_deadbeef_11223344_deadbeef);
    check("s3_fill_tag", fill_tag_o, 0);
    check("s3_fill_index", fill_index_o, 6'h20);

    // ---- different-line store deferred behind the read ----
    step();
    miss_valid_i = 1'b1; miss_addr_i = 32'h408;
    step();
    check("s4_accepted", miss_ready_o, 0);
    miss_valid_i = 1'b0;
    drive_store(32'h300, 32'h55667788, 4'hF);
    step(); st_valid_i = 1'b0;
    check("s4_re_2cyc", mem_re0_o, 1);
    check("s4_mem_addr", mem_addr0_o, 32'h400);
    fill_c = -1; we_c = -1;
    for (int c = 0; c < 40 && (fill_c < 0 || we_c < 0); c++) begin
      step();
      if (mem_we0_o && we_c < 0) we_c = c;
      if (fill_valid_o) begin
        fill_c = c;
        check("s4_no_accept_in_fill", miss_ready_o, 0);
        step(); c++;
        check("s4_ready_after_fill", miss_ready_o, 1);
        if (mem_we0_o && we_c < 0) we_c = c;
      end
    end
    check("s4_fill_seen", fill_c >= 0, 1);
    check("s4_we_after_fill", we_c > fill_c, 1);
    check("s4_fill_data", fill_data_o, ALL_DEAD);
    for (int c = 0; c < 6; c++) step();

    // ---- plain miss at a high address ----
    miss_valid_i = 1'b1; miss_addr_i = 32'h80000010;
    step(); miss_valid_i = 1'b0;
    pulses = 0; cap_addr = '0; cap_data = '0; cap_tag = '0; cap_idx = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mem_re0_o) cap_addr = mem_addr0_o;
      if (fill_valid_o) begin
        pulses++;
        cap_data = fill_data_o; cap_tag = 32'(fill_tag_o); cap_idx = 32'(fill_index_o);
      end
    end
    check("s5_mem_addr", cap_addr, 32'h80000010);
    check("s5_fill_pulses", pulses, 1);
    check("s5_fill_data", cap_data, ALL_DEAD);
    check("s5_fill_tag", cap_tag, 32'h200000);
    check("s5_fill_index", cap_idx, 1);
    check("s5_fill_hold", fill_data_o, ALL_DEAD);

    // ---- asynchronous reset mid-operation ----
    auto_wr = 1'b0; auto_rd = 1'b0;
    step();
    drive_store(32'h600, 32'h1, 4'hF);
    step();
    drive_store(32'h640, 32'h2, 4'hF);
    step(); st_valid_i = 1'b0;
    miss_valid_i = 1'b1; miss_addr_i = 32'h700;
    step(); miss_valid_i = 1'b0;
    step(); step();
    check("s6_busy_miss", miss_ready_o, 0);
    check("s6_busy_wb", wb_empty_o, 0);
    check("s6_wr_addr_pre", mem_wr_addr0_o, 32'h600);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_st_ready", st_ready_o, 1);
    check("s6_rst_miss_ready", miss_ready_o, 1);
    check("s6_rst_wb_empty", wb_empty_o, 1);
    check("s6_rst_strobes", {mem_we0_o, mem_re0_o, fill_valid_o}, 0);
    check("s6_rst_addrs", {mem_addr0_o, mem_wr_addr0_o, mem_wr_data0_o}, 0);
    check("s6_rst_fill", {fill_data_o, fill_tag_o, fill_index_o} != 0, 0);
    step();
    reset = 1'b0;
    snap_we = we_pulses; snap_fill = fill_pulses;
    step();
    manual_done = 1'b1; manual_ready = 1'b1;
    step();
    manual_done = 1'b0; manual_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("s6_stale_idle", {wb_empty_o, miss_ready_o, st_ready_o, fill_valid_o}, 4'b1110);
    end
    check("s6_no_we", we_pulses - snap_we, 0);
    check("s6_no_fill", fill_pulses - snap_fill, 0);
    auto_wr = 1'b1; auto_rd = 1'b1;
    base = wlog.size();
    step();
    drive_store(32'h900, 32'h99, 4'hF);
    step(); st_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (wb_empty_o) seen = 1'b1;
    end
    check("s6_post_drained", seen, 1);
    check("s6_post_writes", wlog.size() - base, 1);
    if (wlog.size() > base) check("s6_post_addr", wlog[base].addr, 32'h900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
